// File: rtl/mem_responder_pkg.sv
// Shared constants and helpers for the memory responder: MMIO register map,
// console FIFO geometry and STATUS register layout.
package mem_responder_pkg;

   // MMIO register offsets relative to MMIO_BASE.
   localparam logic [31:0] MmioOffChar   = 32'h0000_0000;
   localparam logic [31:0] MmioOffStatus = 32'h0000_0004;
   localparam logic [31:0] MmioOffCycle  = 32'h0000_0008;
   localparam logic [31:0] MmioOffHalt   = 32'h0000_000C;

   // Console FIFO geometry.
   localparam int unsigned FifoDepth = 4;
   localparam int unsigned FifoWidth = 8;

   // STATUS register bit positions.
   localparam int unsigned StatusFullBit     = 0;
   localparam int unsigned StatusEmptyBit    = 1;
   localparam int unsigned StatusOverflowBit = 2;

   typedef enum logic [2:0] {
      RegChar,
      RegStatus,
      RegCycle,
      RegHalt,
      RegNone
   } mmio_reg_e;

   // Map a full 32-bit MMIO offset onto a register; anything else is unmapped.
   function automatic mmio_reg_e decode_mmio(input logic [31:0] offset);
      mmio_reg_e reg_sel;
      case (offset)
         MmioOffChar:   reg_sel = RegChar;
         MmioOffStatus: reg_sel = RegStatus;
         MmioOffCycle:  reg_sel = RegCycle;
         MmioOffHalt:   reg_sel = RegHalt;
         default:       reg_sel = RegNone;
      endcase
      return reg_sel;
   endfunction

   function automatic logic [31:0] status_word(input logic full, input logic empty,
                                               input logic overflow);
      logic [31:0] word;
      word                    = '0;
      word[StatusFullBit]     = full;
      word[StatusEmptyBit]    = empty;
      word[StatusOverflowBit] = overflow;
      return word;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Core-facing bus of the memory responder: fetch port, data read/write port
// and console character stream plus halt flag.
interface mem_responder_if;

   logic [31:0] i_address;
   logic [31:0] instruction;
   logic        read;
   logic [31:0] read_address;
   logic [31:0] read_data;
   logic [3:0]  write;
   logic [31:0] write_address;
   logic [31:0] write_data;
   logic [7:0]  char_data;
   logic        char_valid;
   logic        char_ready;
   logic        halt;

   // Core / testbench side.
   modport master (
      output i_address, read, read_address, write, write_address, write_data, char_ready,
      input  instruction, read_data, char_data, char_valid, halt
   );

   // Responder side.
   modport slave (
      input  i_address, read, read_address, write, write_address, write_data, char_ready,
      output instruction, read_data, char_data, char_valid, halt
   );

endinterface

// File: rtl/mem_responder_char_fifo.sv
// Small console FIFO. Head entry is shown combinationally from storage; a push
// into a full FIFO only lands when the same edge pops, otherwise it is dropped
// and the sticky overflow flag is raised.
module char_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             pop;
   logic             push_ok;

   function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign empty      = (count_q == '0);
   assign full       = (count_q == CntW'(DEPTH));
   assign head_valid = !empty;
   assign head_data  = storage[rd_ptr_q];
   assign overflow   = overflow_q;

   // Pop only a valid head; a full FIFO still accepts a push if it pops too.
   assign pop     = head_valid && pop_ready;
   assign push_ok = push && (!full || pop);

   // Next-state for pointers, occupancy and overflow.
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (pop) begin
         rd_ptr_d = inc_ptr(rd_ptr_q);
      end
      if (push_ok) begin
         wr_ptr_d = inc_ptr(wr_ptr_q);
      end
      if (push_ok && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push_ok) begin
         count_d = count_q - 1'b1;
      end
      if (push && !push_ok) begin
         overflow_d = 1'b1;
      end
   end

   // Control state with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage; contents are meaningless until pointed at by a valid head.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         storage[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Simulation-style memory responder: shared word RAM with a registered fetch
// port and a registered data read port, byte-lane writes, and an MMIO window
// holding a console FIFO, status, cycle counter and halt flag.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 16384,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic           clk,
   input  logic           reset,
   mem_responder_if.slave bus
);

   localparam int unsigned AddrW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [31:0] ram [MEM_WORDS];

   logic [29:0] i_idx, r_idx, w_idx;
   logic        i_in_range, r_in_range, w_in_range;
   logic        r_is_mmio, w_is_mmio;
   logic [31:0] r_off, w_off;
   mmio_reg_e   r_reg, w_reg;
   logic        ram_we;
   logic        char_push;
   logic        halt_set;
   logic        fifo_full, fifo_empty, fifo_overflow;

   logic [31:0] fetch_word;
   logic [31:0] ram_rword;
   logic [31:0] mmio_rword;
   logic [31:0] instruction_q, instruction_d;
   logic [31:0] read_data_q, read_data_d;
   logic [31:0] cycle_q;
   logic        halt_q;

   // Byte offset bits are ignored: every access is word aligned.
   logic        unused_addr_bits;
   assign unused_addr_bits = ^{bus.i_address[1:0], bus.read_address[1:0],
                               bus.write_address[1:0]};

   assign i_idx = bus.i_address[31:2];
   assign r_idx = bus.read_address[31:2];
   assign w_idx = bus.write_address[31:2];

   assign i_in_range = ({2'b00, i_idx} < 32'(MEM_WORDS));
   assign r_in_range = ({2'b00, r_idx} < 32'(MEM_WORDS));
   assign w_in_range = ({2'b00, w_idx} < 32'(MEM_WORDS));

   assign r_is_mmio = (bus.read_address >= MMIO_BASE);
   assign w_is_mmio = (bus.write_address >= MMIO_BASE);
   assign r_off     = bus.read_address - MMIO_BASE;
   assign w_off     = bus.write_address - MMIO_BASE;
   assign r_reg     = decode_mmio(r_off);
   assign w_reg     = decode_mmio(w_off);

   assign ram_we    = (bus.write != 4'b0000) && !w_is_mmio && w_in_range;
   assign char_push = w_is_mmio && (w_reg == RegChar) && bus.write[0];
   assign halt_set  = w_is_mmio && (w_reg == RegHalt) && (bus.write != 4'b0000);

   // RAM byte-lane writes; reads elsewhere see the pre-write word this edge.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.write[b]) begin
               ram[w_idx[AddrW-1:0]][8*b +: 8] <= bus.write_data[8*b +: 8];
            end
         end
      end
   end

   // Select fetch and read words; read_data holds unless a read is requested.
   always_comb begin
      fetch_word = '0;
      ram_rword  = '0;
      mmio_rword = '0;
      if (i_in_range) begin
         fetch_word = ram[i_idx[AddrW-1:0]];
      end
      if (r_in_range) begin
         ram_rword = ram[r_idx[AddrW-1:0]];
      end
      case (r_reg)
         RegStatus: mmio_rword = status_word(fifo_full, fifo_empty, fifo_overflow);
         RegCycle:  mmio_rword = cycle_q;
         default:   mmio_rword = '0;
      endcase
      instruction_d = fetch_word;
      read_data_d   = read_data_q;
      if (bus.read) begin
         read_data_d = r_is_mmio ? mmio_rword : ram_rword;
      end
   end

   // Output registers, cycle counter and sticky halt.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instruction_q <= '0;
         read_data_q   <= '0;
         cycle_q       <= '0;
         halt_q        <= 1'b0;
      end else begin
         instruction_q <= instruction_d;
         read_data_q   <= read_data_d;
         cycle_q       <= cycle_q + 32'd1;
         if (halt_set) begin
            halt_q <= 1'b1;
         end
      end
   end

   char_fifo #(
      .DEPTH(FifoDepth),
      .WIDTH(FifoWidth)
   ) u_char_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (char_push),
      .push_data (bus.write_data[7:0]),
      .pop_ready (bus.char_ready),
      .head_data (bus.char_data),
      .head_valid(bus.char_valid),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .overflow  (fifo_overflow)
   );

   assign bus.instruction = instruction_q;
   assign bus.read_data   = read_data_q;
   assign bus.halt        = halt_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM, fetch, MMIO console FIFO, halt, reset.
module tb_mem_responder;

   localparam logic [31:0] Base = 32'h8000_0000;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   passes = 0;

   always #5 clk = ~clk;

   mem_responder_if bus ();

   mem_responder #(
      .MEM_WORDS(16384),
      .MMIO_BASE(Base)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.write_address = a;
      bus.write_data    = d;
      bus.write         = be;
      tick();
      bus.write = 4'b0000;
   endtask

   task automatic do_read(input logic [31:0] a);
      bus.read_address = a;
      bus.read         = 1'b1;
      tick();
      bus.read = 1'b0;
   endtask

   task automatic test_reset();
      reset            = 1'b0;
      bus.read         = 1'b1;
      bus.read_address = 32'h0;
      tick();
      tick();
      checks++; if (bus.instruction !== 32'h0) $display("FAIL reset_instr: got %h want 0", bus.instruction); else passes++;
      checks++; if (bus.read_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.read_data); else passes++;
      checks++; if (bus.char_valid !== 1'b0) $display("FAIL reset_cvalid: got %b want 0", bus.char_valid); else passes++;
      checks++; if (bus.halt !== 1'b0) $display("FAIL reset_halt: got %b want 0", bus.halt); else passes++;
      bus.read = 1'b0;
      reset    = 1'b1;
      do_read(Base + 32'h4);
      checks++; if (bus.read_data !== 32'h2) $display("FAIL reset_status: got %h want 2", bus.read_data); else passes++;
   endtask

   task automatic test_ram();
      do_write(32'h100, 32'hDEADBEEF, 4'b1111);
      do_read(32'h100);
      checks++; if (bus.read_data !== 32'hDEADBEEF) $display("FAIL ram_word: got %h want deadbeef", bus.read_data); else passes++;
      do_write(32'h100, 32'h0000_00AA, 4'b0001);
      do_read(32'h103);
      checks++; if (bus.read_data !== 32'hDEADBEAA) $display("FAIL ram_lane0: got %h want deadbeaa", bus.read_data); else passes++;
      do_write(32'h102, 32'h0055_0000, 4'b0100);
      do_read(32'h100);
      checks++; if (bus.read_data !== 32'hDE55BEAA) $display("FAIL ram_lane2: got %h want de55beaa", bus.read_data); else passes++;
      bus.read_address = 32'h200;
      tick();
      checks++; if (bus.read_data !== 32'hDE55BEAA) $display("FAIL read_hold: got %h want de55beaa", bus.read_data); else passes++;
      // Out-of-range word must neither store nor alias onto word 0.
      do_write(32'h0, 32'h1111_1111, 4'b1111);
      do_write(32'h0001_0000, 32'h1234_5678, 4'b1111);
      do_read(32'h0001_0000);
      checks++; if (bus.read_data !== 32'h0) $display("FAIL ram_oob_read: got %h want 0", bus.read_data); else passes++;
      do_read(32'h0);
      checks++; if (bus.read_data !== 32'h1111_1111) $display("FAIL ram_oob_alias: got %h want 11111111", bus.read_data); else passes++;
      do_read(Base + 32'h10);
      checks++; if (bus.read_data !== 32'h0) $display("FAIL mmio_unmapped: got %h want 0", bus.read_data); else passes++;
   endtask

   task automatic test_fetch();
      bus.i_address = 32'h100;
      tick();
      checks++; if (bus.instruction !== 32'hDE55BEAA) $display("FAIL fetch_word: got %h want de55beaa", bus.instruction); else passes++;
      bus.i_address = 32'h0001_0000;
      tick();
      checks++; if (bus.instruction !== 32'h0) $display("FAIL fetch_oob: got %h want 0", bus.instruction); else passes++;
      bus.i_address = 32'h0;
      tick();
      checks++; if (bus.instruction !== 32'h1111_1111) $display("FAIL fetch_word0: got %h want 11111111", bus.instruction); else passes++;
   endtask

   task automatic test_same_cycle();
      do_write(32'h200, 32'h1, 4'b1111);
      bus.i_address     = 32'h200;
      bus.read_address  = 32'h200;
      bus.read          = 1'b1;
      bus.write_address = 32'h200;
      bus.write_data    = 32'h2;
      bus.write         = 4'b1111;
      tick();
      bus.write = 4'b0000;
      checks++; if (bus.read_data !== 32'h1) $display("FAIL rw_same_read: got %h want 1", bus.read_data); else passes++;
      checks++; if (bus.instruction !== 32'h1) $display("FAIL rw_same_fetch: got %h want 1", bus.instruction); else passes++;
      tick();
      bus.read = 1'b0;
      checks++; if (bus.read_data !== 32'h2) $display("FAIL rw_next_read: got %h want 2", bus.read_data); else passes++;
      checks++; if (bus.instruction !== 32'h2) $display("FAIL rw_next_fetch: got %h want 2", bus.instruction); else passes++;
   endtask

   task automatic test_fifo_overflow();
      logic [7:0] exp;
      bus.char_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         do_write(Base, 32'h41 + 32'(i), 4'b0001);
      end
      checks++; if (bus.char_data !== 8'h41) $display("FAIL fifo_head: got %h want 41", bus.char_data); else passes++;
      do_read(Base + 32'h4);
      checks++; if (bus.read_data !== 32'h5) $display("FAIL status_full_ovf: got %h want 5", bus.read_data); else passes++;
      bus.char_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp = 8'h41 + 8'(i);
         checks++;
         if (bus.char_valid !== 1'b1 || bus.char_data !== exp)
            $display("FAIL drain_%0d: got v=%b %h want v=1 %h", i, bus.char_valid, bus.char_data, exp);
         else passes++;
         tick();
      end
      bus.char_ready = 1'b0;
      checks++; if (bus.char_valid !== 1'b0) $display("FAIL drain_empty: got %b want 0", bus.char_valid); else passes++;
      do_read(Base + 32'h4);
      checks++; if (bus.read_data !== 32'h6) $display("FAIL status_empty_ovf: got %h want 6", bus.read_data); else passes++;
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp_seq [4];
      exp_seq = '{8'h42, 8'h43, 8'h44, 8'h46};
      reset = 1'b0;
      tick();
      reset = 1'b1;
      do_read(Base + 32'h4);
      checks++; if (bus.read_data !== 32'h2) $display("FAIL ovf_cleared: got %h want 2", bus.read_data); else passes++;
      for (int i = 0; i < 4; i++) begin
         do_write(Base, 32'h41 + 32'(i), 4'b0001);
      end
      do_read(Base + 32'h4);
      checks++; if (bus.read_data !== 32'h1) $display("FAIL status_full: got %h want 1", bus.read_data); else passes++;
      bus.char_ready = 1'b1;
      do_write(Base, 32'h46, 4'b0001);
      bus.char_ready = 1'b0;
      do_read(Base + 32'h4);
      checks++; if (bus.read_data !== 32'h1) $display("FAIL full_pushpop_status: got %h want 1", bus.read_data); else passes++;
      bus.char_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.char_valid !== 1'b1 || bus.char_data !== exp_seq[i])
            $display("FAIL full_drain_%0d: got v=%b %h want v=1 %h", i, bus.char_valid, bus.char_data,
                     exp_seq[i]);
         else passes++;
         tick();
      end
      bus.char_ready = 1'b0;
      checks++; if (bus.char_valid !== 1'b0) $display("FAIL full_drain_empty: got %b want 0", bus.char_valid); else passes++;
   endtask

   task automatic test_empty_push_pop();
      bus.char_ready    = 1'b1;
      bus.write_address = Base;
      bus.write_data    = 32'h55;
      bus.write         = 4'b0001;
      #1;
      checks++; if (bus.char_valid !== 1'b0) $display("FAIL empty_pp_valid: got %b want 0", bus.char_valid); else passes++;
      tick();
      bus.write      = 4'b0000;
      bus.char_ready = 1'b0;
      checks++;
      if (bus.char_valid !== 1'b1 || bus.char_data !== 8'h55)
         $display("FAIL empty_pp_kept: got v=%b %h want v=1 55", bus.char_valid, bus.char_data);
      else passes++;
      do_read(Base + 32'h4);
      checks++; if (bus.read_data !== 32'h0) $display("FAIL status_one: got %h want 0", bus.read_data); else passes++;
      bus.char_ready = 1'b1;
      tick();
      bus.char_ready = 1'b0;
   endtask

   task automatic test_halt_reset();
      do_write(Base + 32'hC, 32'hFFFF_FFFF, 4'b0000);
      checks++; if (bus.halt !== 1'b0) $display("FAIL halt_no_enable: got %b want 0", bus.halt); else passes++;
      do_write(Base + 32'hC, 32'h0, 4'b0010);
      checks++; if (bus.halt !== 1'b1) $display("FAIL halt_set: got %b want 1", bus.halt); else passes++;
      tick();
      tick();
      checks++; if (bus.halt !== 1'b1) $display("FAIL halt_sticky: got %b want 1", bus.halt); else passes++;
      do_read(32'h100);
      reset = 1'b0;
      #1;
      checks++; if (bus.halt !== 1'b0) $display("FAIL halt_async_clr: got %b want 0", bus.halt); else passes++;
      checks++; if (bus.read_data !== 32'h0) $display("FAIL rdata_async_clr: got %h want 0", bus.read_data); else passes++;
      tick();
      reset = 1'b1;
      do_read(Base + 32'h8);
      checks++; if (bus.read_data !== 32'h0) $display("FAIL cycle_start: got %h want 0", bus.read_data); else passes++;
      tick();
      tick();
      tick();
      do_read(Base + 32'h8);
      checks++; if (bus.read_data !== 32'h4) $display("FAIL cycle_count: got %h want 4", bus.read_data); else passes++;
   endtask

   initial begin
      reset             = 1'b0;
      bus.i_address     = 32'h0;
      bus.read          = 1'b0;
      bus.read_address  = 32'h0;
      bus.write         = 4'b0000;
      bus.write_address = 32'h0;
      bus.write_data    = 32'h0;
      bus.char_ready    = 1'b0;
      test_reset();
      test_ram();
      test_fetch();
      test_same_cycle();
      test_fifo_overflow();
      test_full_push_pop();
      test_empty_push_pop();
      test_halt_reset();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
